// File: rtl/xb_info_pkg.sv
// ---------------------------------------------------------------------------
// xb_info_pkg
// Shared constants for the INFO mailbox: the signature entry block at the top
// of the index space, CTRL/status register bit positions, the DM/I-O decode
// boundary and the largest supported entry width.
// ---------------------------------------------------------------------------
package xb_info_pkg;

    // Signature entries live at indices VALID_ADDR..VALID_ADDR+3
    localparam logic [7:0] VALID_ADDR = 8'hFC;
    localparam logic [7:0] SIG_0      = 8'h88;
    localparam logic [7:0] SIG_1      = 8'h76;
    localparam logic [7:0] SIG_2      = 8'h82;
    localparam logic [7:0] SIG_3      = 8'h56;

    // CTRL register bit positions
    localparam int CTRL_AUTOINC = 0;
    localparam int CTRL_BYTE_LO = 4;
    localparam int CTRL_BYTE_HI = 5;
    localparam int CTRL_OOR     = 7;

    localparam int MAX_ENTRY_BYTES = 4;

    // CSR addresses at or above this value are reached through the DM bus
    localparam logic [7:0] DM_BASE = 8'h60;

    // Byte 0 of signature entry VALID_ADDR + sel
    function automatic logic [7:0] sig_value(input logic [1:0] sel);
        case (sel)
            2'd0:    return SIG_0;
            2'd1:    return SIG_1;
            2'd2:    return SIG_2;
            default: return SIG_3;
        endcase
    endfunction

endpackage

// File: rtl/xb_info_mb_if.sv
// ---------------------------------------------------------------------------
// xb_info_mb_if
// CPU-side CSR bus of the INFO mailbox.
//   adr/iowe/iore            I/O-space address, write and read strobes
//   ramadr/ramwe/ramre/dm_sel DM-space address, strobes and select
//   dbus_in                  write data
//   dbus_out/out_en          read data and read-data valid
// master: the CPU side, slave: the mailbox.
// ---------------------------------------------------------------------------
interface xb_info_mb_if;
    logic [5:0] adr;
    logic       iowe;
    logic       iore;
    logic [7:0] ramadr;
    logic       ramwe;
    logic       ramre;
    logic       dm_sel;
    logic [7:0] dbus_in;
    logic [7:0] dbus_out;
    logic       out_en;

    modport master (
        output adr, iowe, iore, ramadr, ramwe, ramre, dm_sel, dbus_in,
        input  dbus_out, out_en
    );

    modport slave (
        input  adr, iowe, iore, ramadr, ramwe, ramre, dm_sel, dbus_in,
        output dbus_out, out_en
    );
endinterface

// File: rtl/xb_csr_sel.sv
// ---------------------------------------------------------------------------
// xb_csr_sel
// Address decode for one CSR. Addresses at or above DM_BASE are matched on
// the DM bus (ramadr qualified by dm_sel); lower addresses are matched on
// the 6-bit I/O bus.
//   o_sel  address hit on the bus that owns ADDR
//   o_we   write strobe of that bus, qualified by o_sel
//   o_re   read strobe of that bus, qualified by o_sel
// ---------------------------------------------------------------------------
module xb_csr_sel
    import xb_info_pkg::*;
#(
    parameter logic [7:0] ADDR = 8'hFF
) (
    input  logic [5:0] i_adr,
    input  logic       i_iowe,
    input  logic       i_iore,
    input  logic [7:0] i_ramadr,
    input  logic       i_ramwe,
    input  logic       i_ramre,
    input  logic       i_dm_sel,
    output logic       o_sel,
    output logic       o_we,
    output logic       o_re
);
    localparam bit IS_DM = (ADDR >= DM_BASE);

    logic w_dm_hit;
    logic w_io_hit;

    assign w_dm_hit = i_dm_sel && (i_ramadr == ADDR);
    assign w_io_hit = (i_adr == ADDR[5:0]);

    assign o_sel = IS_DM ? w_dm_hit : w_io_hit;
    assign o_we  = IS_DM ? (w_dm_hit & i_ramwe) : (w_io_hit & i_iowe);
    assign o_re  = IS_DM ? (w_dm_hit & i_ramre) : (w_io_hit & i_iore);
endmodule

// File: rtl/xb_info_mb.sv
// ---------------------------------------------------------------------------
// xb_info_mb
// INFO mailbox: a pointer/data CSR pair exposing a table of multi-byte info
// entries one byte per read, plus a CTRL/status CSR.
//   clk, rstn   clock and asynchronous active-low reset
//   bus         CSR bus (slave modport)
//   info_tbl    packed entries 1..NUM_ENTRIES-1, entry 1 in the LSBs
// Entry 0 reports NUM_ENTRIES-1, indices 0xFC..0xFF return a signature and
// every other index reads as zero and raises the sticky out-of-range flag.
// Upper bytes are snapshotted on the byte-0 read so a multi-byte entry is
// read coherently.
// ---------------------------------------------------------------------------
module xb_info_mb
    import xb_info_pkg::*;
#(
    parameter logic [7:0] XB_INFO_ADDR      = 8'hFF,
    parameter logic [7:0] XB_INFO_CTRL_ADDR = 8'hFE,
    parameter int         NUM_ENTRIES       = 8,
    parameter int         ENTRY_BYTES       = 2
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    xb_info_mb_if.slave                            bus,
    input  logic [(NUM_ENTRIES-1)*ENTRY_BYTES*8-1:0] info_tbl
);
    localparam int         EW        = ENTRY_BYTES * 8;
    localparam logic [1:0] LAST_BYTE = 2'(ENTRY_BYTES - 1);

    generate
        if (NUM_ENTRIES < 2 || NUM_ENTRIES > 252 ||
            ENTRY_BYTES < 1 || ENTRY_BYTES > MAX_ENTRY_BYTES ||
            XB_INFO_ADDR == XB_INFO_CTRL_ADDR) begin : g_bad_param
            $error("xb_info_mb: illegal parameter combination");
        end
    endgenerate

    logic [7:0] idx_f;
    logic [1:0] byte_f;
    logic       autoinc_f;
    logic       oor_f;

    logic w_info_sel, w_info_we, w_info_re;
    logic w_ctrl_sel, w_ctrl_we, w_ctrl_re;

    xb_csr_sel #(.ADDR(XB_INFO_ADDR)) u_sel_info (
        .i_adr(bus.adr), .i_iowe(bus.iowe), .i_iore(bus.iore),
        .i_ramadr(bus.ramadr), .i_ramwe(bus.ramwe), .i_ramre(bus.ramre),
        .i_dm_sel(bus.dm_sel),
        .o_sel(w_info_sel), .o_we(w_info_we), .o_re(w_info_re)
    );

    xb_csr_sel #(.ADDR(XB_INFO_CTRL_ADDR)) u_sel_ctrl (
        .i_adr(bus.adr), .i_iowe(bus.iowe), .i_iore(bus.iore),
        .i_ramadr(bus.ramadr), .i_ramwe(bus.ramwe), .i_ramre(bus.ramre),
        .i_dm_sel(bus.dm_sel),
        .o_sel(w_ctrl_sel), .o_we(w_ctrl_we), .o_re(w_ctrl_re)
    );

    // A read that coincides with a write to the same CSR has no side effects
    logic w_info_rd_adv;
    assign w_info_rd_adv = w_info_re & ~w_info_we;

    // Unpack the table; slot 0 is the entry-count entry
    logic [EW-1:0] w_tbl [NUM_ENTRIES];
    assign w_tbl[0] = EW'(NUM_ENTRIES - 1);
    generate
        for (genvar gi = 1; gi < NUM_ENTRIES; gi++) begin : g_tbl
            assign w_tbl[gi] = info_tbl[(gi-1)*EW +: EW];
        end
    endgenerate

    // Live value of the entry under the pointer
    logic [EW-1:0] w_entry;
    logic          w_oor;
    always_comb begin
        w_entry = '0;
        w_oor   = 1'b0;
        if (idx_f >= VALID_ADDR) begin
            w_entry = EW'(sig_value(idx_f[1:0]));
        end else if (idx_f < 8'(NUM_ENTRIES)) begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                if (idx_f == 8'(e)) w_entry = w_tbl[e];
            end
        end else begin
            w_oor = 1'b1;
        end
    end

    // Byte returned by an INFO read
    logic [7:0] w_rd_byte;
    generate
        if (ENTRY_BYTES > 1) begin : g_snap
            logic [(ENTRY_BYTES-1)*8-1:0] snap_f;
            logic [7:0]                   w_snap_byte;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)
                    snap_f <= '0;
                else if (w_info_rd_adv && byte_f == 2'd0)
                    snap_f <= w_entry[EW-1:8];
            end

            always_comb begin
                w_snap_byte = '0;
                for (int b = 1; b < ENTRY_BYTES; b++) begin
                    if (byte_f == 2'(b)) w_snap_byte = snap_f[(b-1)*8 +: 8];
                end
            end

            assign w_rd_byte = (byte_f == 2'd0) ? w_entry[7:0] : w_snap_byte;
        end else begin : g_nosnap
            assign w_rd_byte = w_entry[7:0];
        end
    endgenerate

    logic [7:0] w_ctrl_data;
    always_comb begin
        w_ctrl_data                            = '0;
        w_ctrl_data[CTRL_OOR]                  = oor_f;
        w_ctrl_data[CTRL_BYTE_HI:CTRL_BYTE_LO] = byte_f;
        w_ctrl_data[CTRL_AUTOINC]              = autoinc_f;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_f     <= 8'd0;
            byte_f    <= 2'd0;
            autoinc_f <= 1'b1;
            oor_f     <= 1'b0;
        end else begin
            if (w_info_we) begin
                idx_f  <= bus.dbus_in;
                byte_f <= 2'd0;
            end else if (w_info_re) begin
                if (byte_f == 2'd0 && w_oor) oor_f <= 1'b1;
                if (byte_f < LAST_BYTE) begin
                    byte_f <= byte_f + 2'd1;
                end else begin
                    byte_f <= 2'd0;
                    if (autoinc_f) idx_f <= idx_f + 8'd1;
                end
            end
            if (w_ctrl_we) begin
                autoinc_f <= bus.dbus_in[CTRL_AUTOINC];
                if (bus.dbus_in[CTRL_OOR]) oor_f <= 1'b0;
            end
        end
    end

    assign bus.out_en   = w_info_re | w_ctrl_re;
    assign bus.dbus_out = (w_info_sel && w_info_re) ? w_rd_byte   :
                          (w_ctrl_sel && w_ctrl_re) ? w_ctrl_data : 8'h00;
endmodule

// File: tb/tb_xb_info_mb.sv
module tb_xb_info_mb;
    localparam int         NE     = 8;
    localparam int         EB     = 2;
    localparam logic [7:0] A_INFO = 8'hFF;
    localparam logic [7:0] A_CTRL = 8'hFE;

    logic clk = 1'b0;
    logic rstn;
    logic [(NE-1)*EB*8-1:0] info_tbl;

    always #5 clk = ~clk;

    xb_info_mb_if bus();

    xb_info_mb #(
        .XB_INFO_ADDR(A_INFO), .XB_INFO_CTRL_ADDR(A_CTRL),
        .NUM_ENTRIES(NE), .ENTRY_BYTES(EB)
    ) dut (
        .clk(clk), .rstn(rstn), .bus(bus), .info_tbl(info_tbl)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", name, act, expv);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_tbl [1:NE-1];
    int          m_idx;
    int          m_byte;
    logic [31:0] m_snap;
    bit          m_auto;
    bit          m_oor;

    task automatic push_tbl();
        for (int e = 1; e < NE; e++) info_tbl[(e-1)*16 +: 16] = m_tbl[e];
    endtask

    task automatic model_reset();
        m_idx = 0; m_byte = 0; m_snap = 0; m_auto = 1; m_oor = 0;
    endtask

    function automatic logic [31:0] ref_entry(input int i, output bit oor);
        oor = 0;
        if (i == 0) return NE - 1;
        if (i < NE) return {16'h0, m_tbl[i]};
        case (i)
            252: return 32'h88;
            253: return 32'h76;
            254: return 32'h82;
            255: return 32'h56;
            default: begin oor = 1; return 0; end
        endcase
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] a);
        logic [7:0] r;
        logic [31:0] v;
        bit o;
        r = 8'h00;
        if (a == A_INFO) begin
            if (m_byte == 0) begin
                v = ref_entry(m_idx, o);
                m_snap = v;
                if (o) m_oor = 1;
                r = v[7:0];
            end else begin
                r = m_snap[m_byte*8 +: 8];
            end
            if (m_byte < EB - 1) m_byte++;
            else begin
                m_byte = 0;
                if (m_auto) m_idx = (m_idx + 1) % 256;
            end
        end else if (a == A_CTRL) begin
            r = {m_oor, 1'b0, 2'(m_byte), 3'b000, m_auto};
        end
        return r;
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [7:0] d);
        if (a == A_INFO) begin m_idx = d; m_byte = 0; end
        else if (a == A_CTRL) begin
            m_auto = d[0];
            if (d[7]) m_oor = 0;
        end
    endtask

    // ---------------- bus tasks ----------------
    task automatic bus_idle();
        bus.adr = 6'h0; bus.iowe = 0; bus.iore = 0;
        bus.ramadr = 8'h0; bus.ramwe = 0; bus.ramre = 0; bus.dm_sel = 0;
        bus.dbus_in = 8'h0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.dm_sel = 1; bus.ramadr = a; bus.dbus_in = d; bus.ramwe = 1;
        @(posedge clk); #1;
        bus_idle();
        model_write(a, d);
        $display("WR  %02h <= %02h", a, d);
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] act, output logic [7:0] mexp);
        @(negedge clk);
        bus.dm_sel = 1; bus.ramadr = a; bus.ramre = 1;
        #1;
        act = bus.dbus_out;
        check("rd_out_en", 8'(bus.out_en), 8'h01);
        mexp = model_read(a);
        @(posedge clk); #1;
        bus_idle();
        $display("RD  %02h -> %02h (model %02h)", a, act, mexp);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         is_wr;
        logic [7:0] addr;
        logic [7:0] data;     // write data or expected read data
        int         idx_exp;  // expected pointer after the step, -1 = skip
    } vec_t;

    vec_t vt[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] act, mexp;
        bus_idle();
        rstn = 0;
        for (int e = 1; e < NE; e++) m_tbl[e] = 16'h0;
        m_tbl[1] = 16'hA55A;
        push_tbl();
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_idx", dut.idx_f, 8'h00);
        check("rst_out_en", 8'(bus.out_en), 8'h00);
        check("rst_dbus_out", bus.dbus_out, 8'h00);
        rstn = 1;

        vt.push_back(vec_t'{1, A_INFO, 8'h00, -1});
        vt.push_back(vec_t'{0, A_INFO, 8'h07, -1});
        vt.push_back(vec_t'{0, A_INFO, 8'h00, 1});
        vt.push_back(vec_t'{0, A_INFO, 8'h5A, -1});
        vt.push_back(vec_t'{0, A_INFO, 8'hA5, 2});
        vt.push_back(vec_t'{1, A_INFO, 8'hFC, -1});
        vt.push_back(vec_t'{0, A_INFO, 8'h88, -1});
        vt.push_back(vec_t'{0, A_INFO, 8'h00, 8'hFD});
        vt.push_back(vec_t'{0, A_INFO, 8'h76, -1});
        vt.push_back(vec_t'{0, A_INFO, 8'h00, -1});
        vt.push_back(vec_t'{0, A_INFO, 8'h82, -1});
        vt.push_back(vec_t'{0, A_INFO, 8'h00, -1});
        vt.push_back(vec_t'{0, A_INFO, 8'h56, -1});
        vt.push_back(vec_t'{0, A_INFO, 8'h00, 0});
        vt.push_back(vec_t'{0, A_CTRL, 8'h01, 0});
        vt.push_back(vec_t'{1, A_INFO, 8'h40, -1});
        vt.push_back(vec_t'{0, A_INFO, 8'h00, -1});
        vt.push_back(vec_t'{0, A_CTRL, 8'h91, -1});
        vt.push_back(vec_t'{1, A_CTRL, 8'h81, -1});
        vt.push_back(vec_t'{0, A_CTRL, 8'h11, -1});
        vt.push_back(vec_t'{0, A_INFO, 8'h00, 8'h41});

        foreach (vt[i]) begin
            if (vt[i].is_wr) wr(vt[i].addr, vt[i].data);
            else begin
                rd(vt[i].addr, act, mexp);
                check($sformatf("vec%0d_data", i), act, vt[i].data);
            end
            if (vt[i].idx_exp >= 0)
                check($sformatf("vec%0d_idx", i), dut.idx_f, 8'(vt[i].idx_exp));
        end

        // Coherency across an info_tbl change between byte reads
        m_tbl[1] = 16'h1234; push_tbl();
        wr(A_INFO, 8'h01);
        rd(A_INFO, act, mexp); check("coh_b0", act, 8'h34);
        m_tbl[1] = 16'hFFFF; push_tbl();
        rd(A_INFO, act, mexp); check("coh_b1", act, 8'h12);

        // Auto-increment disabled: same entry repeats
        m_tbl[1] = 16'h1234; push_tbl();
        wr(A_CTRL, 8'h00);
        wr(A_INFO, 8'h01);
        rd(A_INFO, act, mexp); check("noinc_0", act, 8'h34);
        rd(A_INFO, act, mexp); check("noinc_1", act, 8'h12);
        rd(A_INFO, act, mexp); check("noinc_2", act, 8'h34);
        rd(A_INFO, act, mexp); check("noinc_3", act, 8'h12);
        check("noinc_idx", dut.idx_f, 8'h01);
        wr(A_CTRL, 8'h01);

        // Asynchronous reset in the middle of a multi-byte read
        wr(A_INFO, 8'h01);
        rd(A_INFO, act, mexp); check("prerst_b0", act, 8'h34);
        @(negedge clk); #2;
        rstn = 0;
        #1;
        check("async_rst_idx", dut.idx_f, 8'h00);
        check("inrst_out_en", 8'(bus.out_en), 8'h00);
        check("inrst_dbus_out", bus.dbus_out, 8'h00);
        model_reset();
        @(negedge clk);
        rstn = 1;
        rd(A_CTRL, act, mexp); check("postrst_ctrl", act, 8'h01);
        rd(A_INFO, act, mexp); check("postrst_info", act, 8'h07);

        // Write and read strobes together on INFO: write wins, no advance
        m_tbl[3] = 16'hBEEF; push_tbl();
        @(negedge clk);
        bus.dm_sel = 1; bus.ramadr = A_INFO; bus.dbus_in = 8'h03;
        bus.ramwe = 1; bus.ramre = 1;
        #1;
        check("wr_rd_out_en", 8'(bus.out_en), 8'h01);
        @(posedge clk); #1;
        bus_idle();
        model_write(A_INFO, 8'h03);
        check("wr_rd_idx", dut.idx_f, 8'h03);
        rd(A_CTRL, act, mexp); check("wr_rd_ctrl", act, 8'h01);
        rd(A_INFO, act, mexp); check("wr_rd_info", act, 8'hEF);

        // No response to the wrong bus or an unselected address
        @(negedge clk);
        bus.adr = 6'h3F; bus.iore = 1;
        #1;
        check("io_ignored_en", 8'(bus.out_en), 8'h00);
        check("io_ignored_data", bus.dbus_out, 8'h00);
        bus_idle();
        bus.ramadr = A_INFO; bus.ramre = 1; bus.dm_sel = 0;
        #1;
        check("nosel_en", 8'(bus.out_en), 8'h00);
        bus_idle();
        bus.ramadr = 8'hFD; bus.ramre = 1; bus.dm_sel = 1;
        #1;
        check("otheradr_en", 8'(bus.out_en), 8'h00);
        bus_idle();

        // Randomized traffic against the reference model
        for (int it = 0; it < 400; it++) begin
            int op;
            logic [7:0] d;
            op = $urandom_range(0, 9);
            case (op)
                0: begin
                    case ($urandom_range(0, 3))
                        0: d = 8'($urandom_range(0, NE + 1));
                        1: d = 8'hFC + 8'($urandom_range(0, 3));
                        2: d = 8'hFA + 8'($urandom_range(0, 5));
                        default: d = 8'($urandom);
                    endcase
                    wr(A_INFO, d);
                end
                1: wr(A_CTRL, 8'($urandom));
                2: begin
                    m_tbl[$urandom_range(1, NE - 1)] = 16'($urandom);
                    push_tbl();
                end
                3, 4, 5, 6: begin
                    rd(A_INFO, act, mexp); check("rand_info", act, mexp);
                end
                7, 8: begin
                    rd(A_CTRL, act, mexp); check("rand_ctrl", act, mexp);
                end
                default: check("rand_idx", dut.idx_f, 8'(m_idx));
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
